// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, canonical NOP and reset vector,
// plus the {pc, instr} record carried through the fetch queue.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched {pc, instr} pairs with synchronous flush.
// The head entry is held in its own register so decode sees registered outputs.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int QDEPTH = 2,
    localparam int PTRW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
    localparam int CNTW = $clog2(QDEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic [XLEN-1:0] pushPc_i,
    input  logic [XLEN-1:0] pushInstr_i,
    input  logic            pop_i,
    output logic [CNTW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [XLEN-1:0] headPc_o,
    output logic [XLEN-1:0] headInstr_o
);

    fetch_entry_t    mem_q [QDEPTH];
    fetch_entry_t    head_q, head_d;
    fetch_entry_t    pushEntry;
    logic [PTRW-1:0] rdPtr_q, rdPtr_d;
    logic [PTRW-1:0] wrPtr_q, wrPtr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            isFull, isEmpty, doPush, doPop;

    function automatic logic [PTRW-1:0] ptrInc(input logic [PTRW-1:0] p);
        if (p == PTRW'(QDEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign pushEntry = '{pc: pushPc_i, instr: pushInstr_i};
    assign isFull    = (count_q == CNTW'(QDEPTH));
    assign isEmpty   = (count_q == '0);
    assign doPop     = pop_i && !isEmpty;
    assign doPush    = push_i && (!isFull || doPop);

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        head_d  = head_q;
        if (flush_i) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = ptrInc(wrPtr_q);
            if (doPop)  rdPtr_d = ptrInc(rdPtr_q);
            case ({doPush, doPop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            // The new head is either the incoming word (queue empty after the pop) or the next stored entry.
            if (doPush && (isEmpty || (doPop && count_q == CNTW'(1)))) begin
                head_d = pushEntry;
            end else if (doPop && count_q > CNTW'(1)) begin
                head_d = mem_q[ptrInc(rdPtr_q)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !flush_i) mem_q[wrPtr_q] <= pushEntry;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    assign count_o     = count_q;
    assign full_o      = isFull;
    assign empty_o     = isEmpty;
    assign headPc_o    = head_q.pc;
    assign headInstr_o = head_q.instr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one request in flight to instruction
// memory, queues returned words for decode and handles flushes on redirect.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);

    localparam int CNTW = $clog2(QDEPTH + 1);

    logic [XLEN-1:0] fetchPc_q, fetchPc_d;
    logic [XLEN-1:0] reqPc_q, reqPc_d;
    logic            outstanding_q, outstanding_d;
    logic            drop_q, drop_d;
    logic            imemReq_q, imemReq_d;

    logic [CNTW-1:0] queueCount;
    logic            queueFull, queueEmpty;
    logic            accept, respValid, push, pop;
    int              countNext;
    logic            unusedBits;

    assign accept    = imemReq_q && imem_ready;
    assign respValid = imem_rvalid && outstanding_q;
    assign push      = respValid && !drop_q && !redirect_valid;
    assign pop       = !queueEmpty && out_ready && !redirect_valid;

    always_comb begin
        fetchPc_d     = fetchPc_q;
        reqPc_d       = reqPc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (redirect_valid) begin
            // Anything still in flight after this edge belongs to the old path and must be dropped.
            fetchPc_d     = {redirect_pc[XLEN-1:2], 2'b00};
            outstanding_d = (outstanding_q && !imem_rvalid) || accept;
            drop_d        = (outstanding_q && !imem_rvalid) || accept;
        end else begin
            if (accept) begin
                outstanding_d = 1'b1;
                reqPc_d       = fetchPc_q;
                fetchPc_d     = fetchPc_q + 32'd4;
            end
            if (respValid) begin
                outstanding_d = 1'b0;
                drop_d        = 1'b0;
            end
        end

        countNext = int'(queueCount);
        if (push) countNext = countNext + 1;
        if (pop)  countNext = countNext - 1;
        imemReq_d = !outstanding_d && (countNext < QDEPTH) && !redirect_valid;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetchPc_q     <= RESET_PC;
            reqPc_q       <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            imemReq_q     <= 1'b0;
        end else begin
            fetchPc_q     <= fetchPc_d;
            reqPc_q       <= reqPc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            imemReq_q     <= imemReq_d;
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .pushPc_i    (reqPc_q),
        .pushInstr_i (imem_rdata),
        .pop_i       (pop),
        .count_o     (queueCount),
        .full_o      (queueFull),
        .empty_o     (queueEmpty),
        .headPc_o    (out_pc),
        .headInstr_o (out_instr)
    );

    assign imem_req   = imemReq_q;
    assign imem_addr  = fetchPc_q;
    assign out_valid  = !queueEmpty;
    assign unusedBits = &{1'b0, queueFull, redirect_pc[1:0]};

endmodule
